mem_resp_stage: RTL and testbench



---
 rtl/mem_resp_stage_pkg.sv | 48 ++++
 rtl/mem_resp_stage_resp_fifo.sv | 57 +++++
 rtl/mem_resp_stage.sv | 126 ++++++++++++
 tb/tb_mem_resp_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_stage_pkg.sv
// Shared definitions for the memory-response stage: bus widths, field
// layouts and the load alignment helper.
package mem_resp_stage_pkg;

  // Default sideband width; the stage itself is parametrised on PAYLOAD_W.
  localparam int MRS_PAYLOAD_W        = 64;
  // Bus widths excluding the opaque payload.
  localparam int MRS_ES_TO_MS_BASE_WD = 76;
  localparam int MRS_MS_TO_WS_BASE_WD = 70;
  localparam int MRS_ES_TO_MS_BUS_WD  = MRS_PAYLOAD_W + MRS_ES_TO_MS_BASE_WD;
  localparam int MRS_MS_TO_WS_BUS_WD  = MRS_PAYLOAD_W + MRS_MS_TO_WS_BASE_WD;
  localparam int MRS_FWD_BUS_WD       = 39;

  // load_op = {ld_b, ld_h, ld_w, ld_bu, ld_hu}
  localparam int LD_B  = 4;
  localparam int LD_H  = 3;
  localparam int LD_W  = 2;
  localparam int LD_BU = 1;
  localparam int LD_HU = 0;

  // Non-payload part of the EX->MS bus, LSB at pc.
  typedef struct packed {
    logic        mem_req;
    logic [4:0]  load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } mrs_es_hdr_t;

  // Picks the addressed byte/half out of the response word and extends it.
  function automatic logic [31:0] mrs_load_align(input logic [4:0]  op,
                                                 input logic [1:0]  addr,
                                                 input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{addr, 3'b000} +: 8];
    h = rdata[{addr[1], 4'b0000} +: 16];
    r = rdata;
    if (op[LD_B])       r = {{24{b[7]}}, b};
    else if (op[LD_H])  r = {{16{h[15]}}, h};
    else if (op[LD_BU]) r = {24'd0, b};
    else if (op[LD_HU]) r = {16'd0, h};
    return r;
  endfunction

endpackage

// File: rtl/mem_resp_stage_resp_fifo.sv
// Small synchronous FIFO holding data-SRAM responses that arrived before
// MS could use them. Head is visible combinationally on rdata_o.
module resp_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               cnt_q;
  logic                        do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  // A pop in the same cycle frees the slot, so push-while-full is allowed then.
  assign do_push = push_i & (!full_o | pop_i);
  assign do_pop  = pop_i & !empty_o;

  // Pointer and occupancy tracking; clear empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage write; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM pipeline stage for a data SRAM with addr_ok/data_ok handshake.
// Tracks in-order outstanding requests, buffers early responses, drops
// responses owed to flushed instructions, and aligns/extends load data.
module mem_resp_stage
  import mem_resp_stage_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int PAYLOAD_W       = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ws_allowin,
  output logic                   ms_allowin,
  input  logic                   es_to_ms_valid,
  input  logic [PAYLOAD_W+75:0]  es_to_ms_bus,
  input  logic                   es_req_fire,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata,
  output logic                   ms_req_block,
  output logic                   ms_to_ws_valid,
  output logic [PAYLOAD_W+69:0]  ms_to_ws_bus,
  output logic [MRS_FWD_BUS_WD-1:0] ms_fwd_blk_bus,
  input  logic                   flush
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic                  ms_valid_q;
  logic [PAYLOAD_W+75:0] ms_bus_q;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

  mrs_es_hdr_t           hdr;
  logic [PAYLOAD_W-1:0]  payload;
  logic                  live_ok, mem_wait, bypass, ms_ready_go;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]           fifo_head, rdata_sel, ld_result, final_result;
  logic [CW-1:0]         fifo_count;

  assign hdr     = mrs_es_hdr_t'(ms_bus_q[MRS_ES_TO_MS_BASE_WD-1:0]);
  assign payload = ms_bus_q[PAYLOAD_W+75:MRS_ES_TO_MS_BASE_WD];

  // A response is live only when nothing from a flushed instruction is still owed.
  assign live_ok  = data_sram_data_ok & (drop_cnt_q == '0);
  assign mem_wait = ms_valid_q & hdr.mem_req;
  // Response goes straight to WB only when it is the oldest and WB takes it now.
  assign bypass   = mem_wait & fifo_empty & ws_allowin;

  assign ms_ready_go    = !hdr.mem_req | !fifo_empty | live_ok;
  assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_req_block   = (out_cnt_q == CW'(MAX_OUTSTANDING)) | (drop_cnt_q != '0);

  assign fifo_push = live_ok & !bypass & !flush;
  // Stores pop too: their response carries nothing but must leave the queue.
  assign fifo_pop  = mem_wait & ws_allowin & !fifo_empty & !flush;

  resp_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (flush),
    .wdata_i (data_sram_rdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rdata_sel    = fifo_empty ? data_sram_rdata : fifo_head;
  assign ld_result    = mrs_load_align(hdr.load_op, hdr.alu_result[1:0], rdata_sel);
  assign final_result = (|hdr.load_op) ? ld_result : hdr.alu_result;

  assign ms_to_ws_bus   = {payload, hdr.gr_we, hdr.dest, final_result, hdr.pc};
  assign ms_fwd_blk_bus = {hdr.gr_we & ms_valid_q, hdr.dest, final_result,
                           ms_valid_q & hdr.mem_req & !ms_ready_go};

  // Next outstanding/drop counts; a flush converts everything still owed into drops.
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({es_req_fire, data_sram_data_ok})
      2'b10:   out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
    drop_cnt_d = drop_cnt_q;
    if (flush)
      drop_cnt_d = out_cnt_d;
    else if (data_sram_data_ok && drop_cnt_q != '0)
      drop_cnt_d = drop_cnt_q - CW'(1);
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Stage valid; flush wins over a handoff from EX.
  always_ff @(posedge clk) begin
    if (reset)           ms_valid_q <= 1'b0;
    else if (flush)      ms_valid_q <= 1'b0;
    else if (ms_allowin) ms_valid_q <= es_to_ms_valid;
  end

  // Stage payload register.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin && !flush) ms_bus_q <= es_to_ms_bus;
  end

  // Protocol checks: queue overflow and responses nobody asked for.
  always @(posedge clk) begin
    if (!reset) begin
      a_fifo_ovf:  assert (!(fifo_push && fifo_full && !fifo_pop));
      a_spurious:  assert (!(data_sram_data_ok && out_cnt_q == '0));
      a_fifo_cnt:  assert (fifo_count <= CW'(MAX_OUTSTANDING));
    end
  end

endmodule

// File: tb/tb_mem_resp_stage.sv
module tb_mem_resp_stage;

  localparam int PW = 64;

  logic            clk = 0;
  logic            reset;
  logic            ws_allowin;
  logic            ms_allowin;
  logic            es_to_ms_valid;
  logic [PW+75:0]  es_to_ms_bus;
  logic            es_req_fire;
  logic            data_ok;
  logic [31:0]     rdata;
  logic            ms_req_block;
  logic            ms_to_ws_valid;
  logic [PW+69:0]  ms_to_ws_bus;
  logic [38:0]     fwd;
  logic            flush;

  int total = 0;
  int bad   = 0;
  logic [PW+69:0] sb[$];

  mem_resp_stage #(.MAX_OUTSTANDING(2), .PAYLOAD_W(PW)) dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_req_fire       (es_req_fire),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ms_req_block      (ms_req_block),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_fwd_blk_bus    (fwd),
    .flush             (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mem_req;
    logic [4:0]  op;
    logic        gr_we;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  localparam logic [4:0] OP_B = 5'b10000, OP_H = 5'b01000, OP_W = 5'b00100,
                         OP_BU = 5'b00010, OP_HU = 5'b00001;

  function automatic logic [PW+75:0] mk_es(logic mem_req, logic [4:0] op, logic gr_we,
                                           logic [4:0] dest, logic [31:0] alu, logic [31:0] pc);
    return {32'hA5A5_0000, pc, mem_req, op, gr_we, dest, alu, pc};
  endfunction

  function automatic logic [PW+69:0] mk_ws(logic gr_we, logic [4:0] dest,
                                           logic [31:0] res, logic [31:0] pc);
    return {32'hA5A5_0000, pc, gr_we, dest, res, pc};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Next cycle: inputs change 1 time unit after the edge, pulses default low.
  task automatic nxt();
    @(posedge clk); #1;
    es_req_fire    = 0;
    es_to_ms_valid = 0;
    data_ok        = 0;
    flush          = 0;
    ws_allowin     = 1;
  endtask

  // Issue a load/op from EX into MS and record its expected WB bus.
  task automatic send(logic mem_req, logic [4:0] op, logic gr_we, logic [4:0] dest,
                      logic [31:0] alu, logic [31:0] pc, logic [31:0] exp);
    es_to_ms_valid = 1;
    es_req_fire    = mem_req;
    es_to_ms_bus   = mk_es(mem_req, op, gr_we, dest, alu, pc);
    sb.push_back(mk_ws(gr_we, dest, exp, pc));
  endtask

  // Scoreboard: every WB handoff must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && !flush && ms_to_ws_valid && ws_allowin) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%h", ms_to_ws_bus);
      end else begin
        logic [PW+69:0] e;
        e = sb.pop_front();
        if (ms_to_ws_bus !== e) begin
          bad++;
          $display("FAIL sb_bus got=%h exp=%h", ms_to_ws_bus, e);
        end
      end
    end
  end

  vec_t vt[12];

  initial begin
    vt[0]  = '{1'b1, OP_B,  1'b1, 32'h0000_1003, 32'h80FF_FF00, 32'hFFFF_FF80};
    vt[1]  = '{1'b1, OP_HU, 1'b1, 32'h0000_1002, 32'h80FF_FF00, 32'h0000_80FF};
    vt[2]  = '{1'b1, OP_H,  1'b1, 32'h0000_1002, 32'h80FF_FF00, 32'hFFFF_80FF};
    vt[3]  = '{1'b1, OP_BU, 1'b1, 32'h0000_1001, 32'h80FF_FF00, 32'h0000_00FF};
    vt[4]  = '{1'b1, OP_B,  1'b1, 32'h0000_1000, 32'h80FF_FF00, 32'h0000_0000};
    vt[5]  = '{1'b1, OP_W,  1'b1, 32'h0000_0104, 32'h1234_5678, 32'h1234_5678};
    vt[6]  = '{1'b1, OP_HU, 1'b1, 32'h0000_2000, 32'h1234_8765, 32'h0000_8765};
    vt[7]  = '{1'b1, OP_H,  1'b1, 32'h0000_2000, 32'h1234_8765, 32'hFFFF_8765};
    vt[8]  = '{1'b0, 5'b0,  1'b1, 32'hCAFE_0001, 32'h0,         32'hCAFE_0001};
    vt[9]  = '{1'b1, 5'b0,  1'b0, 32'h0000_0200, 32'h1111_1111, 32'h0000_0200};
    vt[10] = '{1'b1, OP_B,  1'b1, 32'h0000_2001, 32'h1234_8765, 32'hFFFF_FF87};
    vt[11] = '{1'b1, OP_BU, 1'b1, 32'h0000_2002, 32'h1234_8765, 32'h0000_0034};

    reset = 1; ws_allowin = 1; es_to_ms_valid = 0; es_to_ms_bus = '0;
    es_req_fire = 0; data_ok = 0; rdata = '0; flush = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("rst_allowin",   ms_allowin, 1);
    chk("rst_ws_valid",  ms_to_ws_valid, 0);
    chk("rst_req_block", ms_req_block, 0);
    chk("rst_fwd_we",    fwd[38], 0);
    chk("rst_fwd_nrdy",  fwd[0], 0);

    // Table-driven alignment/extension, response latency varies 1..3 cycles.
    for (int i = 0; i < 12; i++) begin
      nxt();
      chk("vec_allowin", ms_allowin, 1);
      send(vt[i].mem_req, vt[i].op, vt[i].gr_we, 5'(i + 1), vt[i].alu,
           32'h1C00_0000 + 32'(i * 4), vt[i].exp);
      if (vt[i].mem_req) begin
        for (int w = 0; w < i % 3; w++) begin
          nxt(); #1;
          chk("vec_stall", ms_to_ws_valid, 0);
          chk("vec_nrdy",  fwd[0], 1);
        end
        nxt();
        data_ok = 1; rdata = vt[i].rdata;
      end
    end
    nxt(); nxt();

    // ld.w at 0x100, response three cycles after fire.
    send(1, OP_W, 1, 5'd7, 32'h100, 32'h1C00_1000, 32'hDEAD_BEEF);
    for (int w = 0; w < 2; w++) begin
      nxt(); #1;
      chk("ldw_stall",     ms_to_ws_valid, 0);
      chk("ldw_fwd_nrdy",  fwd[0], 1);
      chk("ldw_fwd_we",    fwd[38], 1);
      chk("ldw_req_block", ms_req_block, 0);
    end
    nxt(); data_ok = 1; rdata = 32'hDEAD_BEEF; #1;
    chk("ldw_valid",   ms_to_ws_valid, 1);
    chk("ldw_fwd_res", fwd[32:1], 32'hDEAD_BEEF);
    chk("ldw_fwd_rdy", fwd[0], 0);
    nxt();

    // Back-to-back fires, second response lands while WB stalls.
    send(1, OP_W, 1, 5'd8, 32'h300, 32'h1C00_2000, 32'h1111_AAAA);
    nxt(); #1;
    chk("b2b_allowin0", ms_allowin, 0);
    chk("b2b_blk_one",  ms_req_block, 0);
    send(1, OP_W, 1, 5'd9, 32'h304, 32'h1C00_2004, 32'h2222_BBBB);
    nxt();
    es_to_ms_valid = 1; es_to_ms_bus = mk_es(1, OP_W, 1, 5'd9, 32'h304, 32'h1C00_2004);
    data_ok = 1; rdata = 32'h1111_AAAA; #1;
    chk("b2b_blk_full", ms_req_block, 1);
    chk("b2b_bypass",   ms_allowin, 1);
    nxt(); ws_allowin = 0; data_ok = 1; rdata = 32'h2222_BBBB; #1;
    chk("b2b_blk_fall", ms_req_block, 0);
    chk("b2b_ws_stall", ms_allowin, 0);
    nxt(); rdata = 32'h0; #1;
    chk("b2b_from_fifo", ms_to_ws_valid, 1);
    chk("b2b_fifo_res",  ms_to_ws_bus[63:32], 32'h2222_BBBB);
    nxt(); #1;
    chk("b2b_empty", ms_to_ws_valid, 0);

    // Flush with two outstanding; both later responses are dropped.
    send(1, OP_W, 1, 5'd10, 32'h400, 32'h1C00_3000, 32'hBAD0_0001);
    nxt(); send(1, OP_W, 1, 5'd11, 32'h404, 32'h1C00_3004, 32'hBAD0_0002);
    nxt(); flush = 1; sb.delete();
    nxt(); #1;
    chk("fl2_valid",   ms_to_ws_valid, 0);
    chk("fl2_allowin", ms_allowin, 1);
    chk("fl2_block",   ms_req_block, 1);
    chk("fl2_nrdy",    fwd[0], 0);
    data_ok = 1; rdata = 32'hBAD0_0001; #1;
    chk("fl2_drop1", ms_req_block, 1);
    nxt(); #1;
    chk("fl2_still", ms_req_block, 1);
    data_ok = 1; rdata = 32'hBAD0_0002; #1;
    chk("fl2_drop2", ms_req_block, 1);
    nxt(); #1;
    chk("fl2_release", ms_req_block, 0);
    send(1, OP_W, 1, 5'd12, 32'h408, 32'h1C00_3008, 32'h600D_C0DE);
    nxt(); data_ok = 1; rdata = 32'h600D_C0DE; #1;
    chk("fl2_new_valid", ms_to_ws_valid, 1);
    nxt();

    // Flush coincident with data_ok and a new fire, FIFO holding one entry.
    send(1, OP_W, 1, 5'd13, 32'h500, 32'h1C00_4000, 32'hD0D0_D0D0);
    nxt(); ws_allowin = 0; data_ok = 1; rdata = 32'hD0D0_D0D0;
    es_to_ms_valid = 1; es_req_fire = 1;
    es_to_ms_bus = mk_es(1, OP_W, 1, 5'd14, 32'h504, 32'h1C00_4004);
    nxt(); flush = 1; data_ok = 1; rdata = 32'hE0E0_E0E0; es_req_fire = 1; sb.delete();
    nxt(); #1;
    chk("flc_valid", ms_to_ws_valid, 0);
    chk("flc_block", ms_req_block, 1);
    data_ok = 1; rdata = 32'hF0F0_F0F0;
    nxt(); #1;
    chk("flc_release", ms_req_block, 0);
    send(1, OP_W, 1, 5'd15, 32'h600, 32'h1C00_4008, 32'h0123_ABCD);
    nxt(); data_ok = 1; rdata = 32'h0123_ABCD; #1;
    chk("flc_new_valid", ms_to_ws_valid, 1);
    chk("flc_new_res",   ms_to_ws_bus[63:32], 32'h0123_ABCD);
    nxt();

    // Reset while waiting with one FIFO entry and one request outstanding.
    send(1, OP_W, 1, 5'd16, 32'h700, 32'h1C00_5000, 32'h7777_7777);
    nxt(); ws_allowin = 0; data_ok = 1; rdata = 32'h7777_7777;
    nxt(); ws_allowin = 0; es_to_ms_valid = 1; es_req_fire = 1;
    es_to_ms_bus = mk_es(1, OP_W, 1, 5'd17, 32'h704, 32'h1C00_5004);
    nxt(); reset = 1; sb.delete();
    nxt(); reset = 0; #1;
    chk("mrst_allowin", ms_allowin, 1);
    chk("mrst_valid",   ms_to_ws_valid, 0);
    chk("mrst_block",   ms_req_block, 0);
    chk("mrst_fwd_we",  fwd[38], 0);
    chk("mrst_nrdy",    fwd[0], 0);
    send(1, OP_W, 1, 5'd18, 32'h800, 32'h1C00_6000, 32'h8888_9999);
    nxt(); data_ok = 1; rdata = 32'h8888_9999; #1;
    chk("mrst_new_valid", ms_to_ws_valid, 1);
    chk("mrst_new_res",   ms_to_ws_bus[63:32], 32'h8888_9999);
    nxt(); nxt();

    chk("sb_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
